// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, handler vector
// and the EPC computation used when a request is taken.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Word-aligned PC of the faulting instruction, backed up to the branch
  // when the instruction sits in a delay slot.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return (pc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Interrupt/exception request arbitration and next-ExcCode selection;
// interrupts win over a simultaneous exception.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [5:0] i_im,
  input  logic [5:0] i_hw_int,
  input  logic [4:0] i_exc_code,
  output logic       o_req,
  output logic       o_int_req,
  output logic [4:0] o_next_exc
);

  logic w_exc_req;

  assign o_int_req  = i_ie & ~i_exl & (|(i_hw_int & i_im));
  assign w_exc_req  = (i_exc_code != 5'd0) & ~i_exl;
  assign o_req      = o_int_req | w_exc_req;
  assign o_next_exc = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) at the MEM stage;
// raises the pipeline flush/redirect request and serves mfc0/mtc0/eret.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2019_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcIn,
  input  logic        bdIn,
  input  logic [4:0]  excCodeIn,
  input  logic [5:0]  hwInt,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eretIn,
  output logic [31:0] rdata,
  output logic [31:0] epcOut,
  output logic        reqOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_req;
  logic        w_int_req;
  logic [4:0]  w_next_exc;

  cp0_req_arb u_req_arb (
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_im       (r_im),
    .i_hw_int   (hwInt),
    .i_exc_code (excCodeIn),
    .o_req      (w_req),
    .o_int_req  (w_int_req),
    .o_next_exc (w_next_exc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= hwInt;
      if (w_req) begin
        // A write from the faulting instruction must not commit.
        r_exl      <= 1'b1;
        r_exc_code <= w_next_exc;
        r_bd       <= bdIn;
        r_epc      <= epc_of(pcIn, bdIn);
      end else if (we) begin
        case (addr)
          REG_SR: begin
            r_im  <= wdata[15:10];
            r_exl <= wdata[1];
            r_ie  <= wdata[0];
          end
          REG_EPC: r_epc <= wdata;
          default: ;
        endcase
      end else if (eretIn) begin
        r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_SR:    rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
      REG_CAUSE: rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
      REG_EPC:   rdata = r_epc;
      REG_PRID:  rdata = PRID;
      default:   rdata = 32'd0;
    endcase
  end

  assign reqOut = w_req;
  assign epcOut = r_epc;

  // Tie-in keeps the interrupt-request tap observable for debug visibility.
  logic w_unused;
  assign w_unused = w_int_req;

endmodule
